conv_accum_pool: RTL and testbench

// Output stage for the multi-channel convolution datapath. Takes NUM_PE parallel partial-sum streams
// (one per output channel) and accumulates them over IN_FM_CH input-channel passes in a per-PE
// OUT_SIZE x OUT_SIZE accumulator. On the final pass it requantises, applies ReLU and an optional

---
 rtl/conv_accum_pool.sv | 176 +++++++++++++++++
 tb/tb_conv_accum_pool.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_accum_pool.sv
// Multi-pass partial-sum accumulator with requantisation, ReLU, optional max-pool and a valid/ready output.
// Define CONV_ACC_BIAS_EN to add the per-lane i_bias port, which is summed in on the final pass.
module conv_accum_pool #(
  parameter int NUM_PE   = 4,
  parameter int ACC_W    = 32,
  parameter int DW       = 16,
  parameter int OUT_SIZE = 8,
  parameter int IN_FM_CH = 3,
  parameter int POOL     = 2,
  parameter int SHIFT    = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [ACC_W*NUM_PE-1:0] i_psum,
`ifdef CONV_ACC_BIAS_EN
  input  logic [ACC_W*NUM_PE-1:0] i_bias,
`endif
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [DW*NUM_PE-1:0]    o_data,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int RW    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int CW    = (IN_FM_CH > 1) ? $clog2(IN_FM_CH) : 1;
  localparam int NPW   = OUT_SIZE / POOL;
  localparam int PW    = (NPW > 1) ? $clog2(NPW) : 1;
  localparam int DEPTH = OUT_SIZE * OUT_SIZE;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [RW-1:0]           LAST_RC     = RW'(OUT_SIZE - 1);
  localparam logic [CW-1:0]           LAST_ACC_CH = CW'((IN_FM_CH > 1) ? IN_FM_CH - 2 : 0);
  localparam logic signed [ACC_W-1:0] YMAX        = ACC_W'((1 << (DW - 1)) - 1);

  if (POOL < 1 || (OUT_SIZE % POOL) != 0) begin : g_pool_check
    $error("conv_accum_pool: OUT_SIZE must be a multiple of POOL");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, DONE} state_t;

  state_t        state;
  logic [CW-1:0] ch;
  logic [RW-1:0] row, col;
  logic          in_done;

  logic signed [ACC_W-1:0] acc_mem  [NUM_PE][DEPTH];
  logic signed [DW-1:0]    pool_buf [NUM_PE][NPW];

  logic                    accept, last_rc, pool_origin, issue;
  logic [AW-1:0]           addr;
  logic [PW-1:0]           pidx;
  logic signed [ACC_W-1:0] sum       [NUM_PE];
  logic signed [DW-1:0]    pool_next [NUM_PE];
  logic [DW*NUM_PE-1:0]    issue_data;

  assign o_busy = (state != IDLE);

  always_comb begin
    o_ready     = ((state == ACCUM) || (state == FINAL && !in_done)) && (!o_valid || i_ready);
    accept      = i_valid && o_ready;
    last_rc     = (row == LAST_RC) && (col == LAST_RC);
    addr        = AW'(int'(row) * OUT_SIZE + int'(col));
    pidx        = PW'(int'(col) / POOL);
    pool_origin = ((int'(row) % POOL) == 0) && ((int'(col) % POOL) == 0);
    issue       = ((int'(row) % POOL) == POOL - 1) && ((int'(col) % POOL) == POOL - 1);
  end

  // Channel 0 ignores the stale accumulator contents, so the RAM never needs clearing.
  always_comb begin
    logic signed [ACC_W-1:0] s, q, bias;
    logic signed [DW-1:0]    y;
    s          = '0;
    q          = '0;
    bias       = '0;
    y          = '0;
    issue_data = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      sum[p]       = '0;
      pool_next[p] = '0;
    end
    for (int p = 0; p < NUM_PE; p++) begin
      sum[p] = ((ch == '0) ? '0 : acc_mem[p][addr]) + $signed(i_psum[p*ACC_W +: ACC_W]);
`ifdef CONV_ACC_BIAS_EN
      bias = $signed(i_bias[p*ACC_W +: ACC_W]);
`else
      bias = '0;
`endif
      s = sum[p] + bias;
      q = s >>> SHIFT;
      if (q < 0)
        y = '0;
      else if (q > YMAX)
        y = YMAX[DW-1:0];
      else
        y = q[DW-1:0];
      pool_next[p] = (pool_origin || y > pool_buf[p][pidx]) ? y : pool_buf[p][pidx];
      issue_data[p*DW +: DW] = pool_next[p];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && accept) begin
      for (int p = 0; p < NUM_PE; p++) begin
        if (state == ACCUM)
          acc_mem[p][addr] <= sum[p];
        else
          pool_buf[p][pidx] <= pool_next[p];
      end
    end
  end

  // The frame only finishes once the final window result has been taken downstream.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      ch      <= '0;
      row     <= '0;
      col     <= '0;
      in_done <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (accept && state == FINAL && issue) begin
        o_valid <= 1'b1;
        o_data  <= issue_data;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      if (accept) begin
        if (col == LAST_RC) begin
          col <= '0;
          if (row == LAST_RC) begin
            row <= '0;
            ch  <= ch + 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            state   <= (IN_FM_CH == 1) ? FINAL : ACCUM;
            ch      <= '0;
            row     <= '0;
            col     <= '0;
            in_done <= 1'b0;
          end
        end
        ACCUM: begin
          if (accept && last_rc && ch == LAST_ACC_CH)
            state <= FINAL;
        end
        FINAL: begin
          if (accept && last_rc)
            in_done <= 1'b1;
          if (in_done && o_valid && i_ready) begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_accum_pool.sv
// Directed bench: a 3-pass/2x2-pool/shift-8 instance and a 1-pass/no-pool/shift-0 instance.
module tb_conv_accum_pool;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start0 = 1'b0, start1 = 1'b0;
  logic         i_valid = 1'b0, i_ready = 1'b0;
  logic [127:0] i_psum = '0;
  logic         rdy0, vld0, busy0, done0;
  logic         rdy1, vld1, busy1, done1;
  logic [63:0]  dat0, dat1;
`ifdef CONV_ACC_BIAS_EN
  logic [127:0] bias = '0;
`endif

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [127:0] psum;
    logic [63:0]  exp;
  } vec_t;
  localparam int NV = 6;
  vec_t vecs [NV];

  logic [63:0] got     [64];
  logic [63:0] ref_out [16];

  always #5 clk = ~clk;

  conv_accum_pool #(.NUM_PE(4), .ACC_W(32), .DW(16), .OUT_SIZE(8), .IN_FM_CH(3), .POOL(2), .SHIFT(8)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_valid(i_valid), .o_ready(rdy0), .i_psum(i_psum),
`ifdef CONV_ACC_BIAS_EN
    .i_bias(bias),
`endif
    .o_valid(vld0), .i_ready(i_ready), .o_data(dat0), .o_busy(busy0), .o_done(done0));

  conv_accum_pool #(.NUM_PE(4), .ACC_W(32), .DW(16), .OUT_SIZE(8), .IN_FM_CH(1), .POOL(1), .SHIFT(0)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_valid(i_valid), .o_ready(rdy1), .i_psum(i_psum),
`ifdef CONV_ACC_BIAS_EN
    .i_bias(bias),
`endif
    .o_valid(vld1), .i_ready(i_ready), .o_data(dat1), .o_busy(busy1), .o_done(done1));

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic signed [31:0] gen_psum(int mode, int lane, int e);
    int ch = e / 64;
    int r  = (e % 64) / 8;
    int c  = e % 8;
    int v;
    case (mode)
      0: return 32'sd256;
      1: begin
        if (ch < 2) return 32'sd0;
        if (lane == 0 && r < 2 && c < 2) begin
          case (r * 2 + c)
            0:       v = 1;
            1:       v = 9;
            2:       v = -3;
            default: v = 4;
          endcase
          return 32'(v * 256);
        end
        return 32'(((((r * 8 + c) * (lane + 3) + lane * 7) % 23) - 5) * 256);
      end
      2: begin
        case (lane)
          0:       return (ch == 2) ? -32'sd5000 : 32'sd0;
          1:       return (ch == 2) ? 32'sd1073741824 : 32'sd0;
          2:       return (ch < 2) ? 32'sd1073741824 : 32'sd0;
          default: return (ch == 0) ? 32'((r * 8 + c) * 300 - 5000) : ((ch == 1) ? 32'sd100 : 32'sd7);
        endcase
      end
      3: return 32'(e + 64 * lane);
      default: begin
        if (e < NV) return vecs[e].psum[lane*32 +: 32];
        return 32'(e);
      end
    endcase
  endfunction

  function automatic logic [15:0] model_y(int mode, int lane, int r, int c);
    logic signed [31:0] s, q;
    s = '0;
    for (int ch = 0; ch < 3; ch++) s = s + gen_psum(mode, lane, ch * 64 + r * 8 + c);
    q = s >>> 8;
    if (q < 0) return 16'd0;
    if (q > 32767) return 16'd32767;
    return q[15:0];
  endfunction

  function automatic logic [63:0] model_pool(int mode, int wr, int wc);
    logic [63:0] res;
    logic [15:0] m, y;
    res = '0;
    for (int lane = 0; lane < 4; lane++) begin
      m = '0;
      for (int k = 0; k < 4; k++) begin
        y = model_y(mode, lane, wr * 2 + k / 2, wc * 2 + k % 2);
        if (y > m) m = y;
      end
      res[lane*16 +: 16] = m;
    end
    return res;
  endfunction

  // Runs one frame on dut0 (which=0) or dut1 (which=1); stall 1 = 10-cycle hold, 2 = toggled i_ready.
  task automatic applyStimulus(input int which, input int mode, input int stall, output int n_out,
                               output int n_done, output bit stable_ok, output bit busy_after);
    int total = (which == 1) ? 64 : 192;
    int e = 0, stalled = 0, post = 0, cyc = 0;
    logic [63:0] held = '0, dat;
    logic rdy, vld, dn;
    n_out = 0; n_done = 0; stable_ok = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    if (which == 1) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    while (cyc < 4000 && post < 3) begin
      vld = (which == 1) ? vld1 : vld0;
      dat = (which == 1) ? dat1 : dat0;
      if (stall == 1 && vld && stalled < 10) begin
        if (stalled == 0) held = dat;
        i_ready = 1'b0;
      end else if (stall == 2) i_ready = (cyc % 3 != 0);
      else i_ready = 1'b1;
      i_valid = (e < total);
      for (int l = 0; l < 4; l++) i_psum[l*32 +: 32] = gen_psum(mode, l, e);
      #1;
      rdy = (which == 1) ? rdy1 : rdy0;
      dn  = (which == 1) ? done1 : done0;
      dat = (which == 1) ? dat1 : dat0;
      if (stall == 1 && !i_ready) begin
        stalled++;
        if (dat !== held || rdy !== 1'b0) stable_ok = 1'b0;
      end
      if (dn) n_done++;
      if (n_done > 0) post++;
      if (i_valid && rdy) e++;
      if (vld && i_ready) begin
        if (n_out < 64) got[n_out] = dat;
        n_out++;
      end
      cyc++;
      @(negedge clk);
    end
    if (post < 3) $display("[TB] FAIL frame_timeout: got %0d cycles, expected done within 4000", cyc);
    i_valid = 1'b0;
    busy_after = (which == 1) ? busy1 : busy0;
  endtask

  initial begin
    int n_out, n_done;
    bit stable_ok, busy_after, saw_valid;
    logic [15:0] kk;

    vecs[0] = '{psum: {32'sd3, 32'sd2, 32'sd1, 32'sd0},                           exp: {16'd3, 16'd2, 16'd1, 16'd0}};
    vecs[1] = '{psum: {32'sd7, 32'sd100, -32'sd100000, -32'sd1},                  exp: {16'd7, 16'd100, 16'd0, 16'd0}};
    vecs[2] = '{psum: {-32'sd32768, 32'sd65535, 32'sd32768, 32'sd32767},          exp: {16'd0, 16'd32767, 16'd32767, 16'd32767}};
    vecs[3] = '{psum: {32'sd1234, 32'h7FFF_FFFF, 32'h8000_0000, 32'h4000_0000},   exp: {16'd1234, 16'd32767, 16'd0, 16'd32767}};
    vecs[4] = '{psum: {-32'sd5000, 32'sd40000, 32'sd0, 32'sd32766},               exp: {16'd0, 16'd32767, 16'd0, 16'd32766}};
    vecs[5] = '{psum: {32'sd16384, 32'sd4096, 32'sd256, 32'sd255},                exp: {16'd16384, 16'd4096, 16'd256, 16'd255}};

    rst = 1'b1; i_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_valid0", 64'(vld0), 64'd0);
    checkOutput("rst_data0", dat0, 64'd0);
    checkOutput("rst_done0", 64'(done0), 64'd0);
    checkOutput("rst_busy0", 64'(busy0), 64'd0);
    checkOutput("rst_ready0", 64'(rdy0), 64'd0);
    checkOutput("rst_valid1", 64'(vld1), 64'd0);
    rst = 1'b0;

    $display("[TB] single-pass ramp frame");
    applyStimulus(1, 3, 0, n_out, n_done, stable_ok, busy_after);
    checkOutput("ramp_count", 64'(n_out), 64'd64);
    checkOutput("ramp_done", 64'(n_done), 64'd1);
    checkOutput("ramp_idle", 64'(busy_after), 64'd0);
    for (int k = 0; k < 64; k++) begin
      kk = 16'(k);
      checkOutput("ramp_data", got[k], {kk + 16'd192, kk + 16'd128, kk + 16'd64, kk});
    end

    $display("[TB] requant/ReLU/saturation vector table");
    applyStimulus(1, 4, 0, n_out, n_done, stable_ok, busy_after);
    checkOutput("vec_count", 64'(n_out), 64'd64);
    for (int i = 0; i < NV; i++) checkOutput("vec_data", got[i], vecs[i].exp);
    for (int k = NV; k < 64; k++) begin
      kk = 16'(k);
      checkOutput("vec_tail", got[k], {kk, kk, kk, kk});
    end

    $display("[TB] reset mid-frame");
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; i_valid = 1'b1; i_ready = 1'b0;
    for (int l = 0; l < 4; l++) i_psum[l*32 +: 32] = 32'sd256;
    repeat (160) @(negedge clk);
    #1;
    checkOutput("pre_rst_valid", 64'(vld0), 64'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; i_ready = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 64'(vld0), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy0), 64'd0);
    checkOutput("mid_rst_ready", 64'(rdy0), 64'd0);
    saw_valid = 1'b0;
    repeat (5) begin
      @(negedge clk); #1;
      if (vld0 || busy0) saw_valid = 1'b1;
    end
    checkOutput("post_rst_quiet", 64'(saw_valid), 64'd0);
    i_valid = 1'b0;

    $display("[TB] 3-pass frame with 10-cycle output stall");
    applyStimulus(0, 0, 1, n_out, n_done, stable_ok, busy_after);
    checkOutput("const_count", 64'(n_out), 64'd16);
    checkOutput("const_done", 64'(n_done), 64'd1);
    checkOutput("stall_stable", 64'(stable_ok), 64'd1);
    checkOutput("const_idle", 64'(busy_after), 64'd0);
    for (int k = 0; k < 16; k++) checkOutput("const_data", got[k], {4{16'd3}});

    $display("[TB] max-pool frame, free-running then toggled i_ready");
    applyStimulus(0, 1, 0, n_out, n_done, stable_ok, busy_after);
    checkOutput("pool_count", 64'(n_out), 64'd16);
    checkOutput("pool_win0", got[0], {16'd16, 16'd14, 16'd15, 16'd9});
    for (int k = 0; k < 16; k++) begin
      ref_out[k] = got[k];
      checkOutput("pool_data", got[k], model_pool(1, k / 4, k % 4));
    end
    applyStimulus(0, 1, 2, n_out, n_done, stable_ok, busy_after);
    checkOutput("toggle_count", 64'(n_out), 64'd16);
    checkOutput("toggle_done", 64'(n_done), 64'd1);
    for (int k = 0; k < 16; k++) checkOutput("toggle_data", got[k], ref_out[k]);

    $display("[TB] ReLU/saturation/wrap frame");
    applyStimulus(0, 2, 0, n_out, n_done, stable_ok, busy_after);
    checkOutput("relu_count", 64'(n_out), 64'd16);
    for (int k = 0; k < 16; k++) begin
      checkOutput("relu_neg", 64'(got[k][15:0]), 64'd0);
      checkOutput("sat_pos", 64'(got[k][31:16]), 64'd32767);
      checkOutput("wrap_neg", 64'(got[k][47:32]), 64'd0);
      checkOutput("mixed_lane3", got[k], model_pool(2, k / 4, k % 4));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
